// File: rtl/sr_reg_dump.sv
// sr_reg_dump
//   Reader side of the CPU debug register port. On a start pulse it walks
//   regAddr from FIRST_REG to LAST_REG. For each register it captures the
//   32-bit regData word once, after a one-cycle settle. It then streams the
//   word out as four bytes, little-endian, on a valid/ready byte interface.
//   The CPU is never stalled.
//
// Ports
//   clk       in   1   clock, all state updates on posedge
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   begin a dump (sampled only while idle)
//   abort     in   1   synchronous cancel, highest priority
//   busy      out  1   high whenever not idle
//   done      out  1   one-cycle pulse after the last byte of LAST_REG
//   regAddr   out  5   debug register address to the CPU
//   regData   in   32  debug register data (combinational in regAddr)
//   tx_data   out  8   byte stream data
//   tx_valid  out  1   byte stream valid
//   tx_ready  in   1   byte stream ready

module sr_reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    if ((FIRST_REG > LAST_REG) || (FIRST_REG < 0) || (LAST_REG > 31)) begin : g_param_check
        $error("sr_reg_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] C_FIRST = 5'(FIRST_REG);
    localparam logic [4:0] C_LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic [4:0]  r_reg_addr;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_xfer;
    logic        w_last_byte;
    logic        w_last_reg;

    // Little-endian byte lane select of a captured word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            2'd3:    return w[31:24];
            default: return 8'd0;
        endcase
    endfunction

    // tx_valid is always high in SEND, so a transfer is simply SEND & ready.
    assign w_xfer      = (r_state == S_SEND) && tx_ready;
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_reg  = (r_reg_addr == C_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_ADDR: w_next = S_SEND;
                S_SEND: begin
                    if (w_xfer && w_last_byte) begin
                        if (w_last_reg) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_ADDR;
                        end
                    end else begin
                        w_next = S_SEND;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Status and handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            r_tx_valid <= (w_next == S_SEND);
        end
    end

    // Address walk, word capture and byte sequencing. On abort this state
    // just holds; a new start re-initialises it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_addr <= 5'd0;
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
            r_tx_data  <= 8'd0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_reg_addr <= C_FIRST;
                    end
                end
                S_ADDR: begin
                    // regData has had a full cycle to settle on regAddr.
                    r_word     <= regData;
                    r_byte_idx <= 2'd0;
                    r_tx_data  <= regData[7:0];
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (!w_last_byte) begin
                            r_tx_data <= byte_sel(r_word, r_byte_idx + 2'd1);
                        end else if (!w_last_reg) begin
                            r_reg_addr <= r_reg_addr + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign regAddr  = r_reg_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
